bht_predictor: RTL and testbench

- Parametrised per-PC branch direction predictor for the IF stage; replaces the single global saturating counter.
- Holds ENTRIES saturating counters indexed by fetch PC. In MODE 1 (gshare) the index is XORed with a global history register.
- Lookup is combinational against the registered table, so IF can redirect in the same cycle. EX sends resolved outcomes back one per cycle.
- Includes a table-clear FSM and 32-bit performance counters.

---
 rtl/bht_predictor_pkg.sv | 20 ++
 rtl/bht_table.sv | 21 ++
 rtl/bht_predictor.sv | 70 +++++++
 tb/tb_bht_predictor.sv | 139 +++++++++++++
 4 files changed

// File: rtl/bht_predictor_pkg.sv
// bht_predictor_pkg: shared FSM states, counter helpers and index function for the BHT
package bht_predictor_pkg;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;
  localparam int IDX_MAX = 10;
  function automatic logic [3:0] weak_nt(int bits);
    return 4'((1 << (bits - 1)) - 1);
  endfunction
  function automatic logic [3:0] sat_inc(logic [3:0] v, int bits);
    return (int'(v) == (1 << bits) - 1) ? v : v + 4'd1;
  endfunction
  function automatic logic [3:0] sat_dec(logic [3:0] v);
    return (v == 4'd0) ? v : v - 4'd1;
  endfunction
  function automatic logic [IDX_MAX-1:0] bht_idx(logic [31:0] pc, logic [IDX_MAX-1:0] hist,
                                                 int lsb, int idx_w, bit gshare);
    logic [31:0] m;
    m = (32'd1 << idx_w) - 32'd1;
    return IDX_MAX'(((pc >> lsb) ^ (gshare ? {22'd0, hist} : 32'd0)) & m);
  endfunction
endpackage

// File: rtl/bht_table.sv
// bht_table: register array with async lookup/update read ports and one sync write port
module bht_table #(
  parameter int ENTRIES = 64,
  parameter int W = 2,
  localparam int AW = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] ra_addr,
  output logic [W-1:0]  ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [W-1:0]  rb_data
);
  logic [W-1:0] mem [ENTRIES];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];
endmodule

// File: rtl/bht_predictor.sv
// bht_predictor: per-PC bimodal/gshare branch predictor with table-clear FSM and stats
module bht_predictor
  import bht_predictor_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int CTR_BITS = 2,
  parameter int PC_LSB = 1,
  parameter int MODE = 0,
  parameter int HIST_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          lookup_pc,
  output logic                 predict_taken,
  output logic [HIST_BITS-1:0] lookup_hist,
  output logic                 ready,
  input  logic                 update_valid,
  input  logic [31:0]          update_pc,
  input  logic [HIST_BITS-1:0] update_hist,
  input  logic                 update_taken,
  input  logic                 update_mispredict,
  output logic [31:0]          stat_updates,
  output logic [31:0]          stat_mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);
  state_e state, state_nxt;
  logic [IDX_W-1:0] ptr, lk_idx, up_idx, waddr;
  logic [CTR_BITS-1:0] lk_ctr, up_ctr, wdata;
  logic [HIST_BITS-1:0] ghr;
  logic accept, we;
  always_ff @(posedge clk)
    state <= rst ? INIT : state_nxt;
  always_comb
    state_nxt = (state == INIT && ptr == IDX_W'(ENTRIES - 1)) ? RUN : state;
  always_comb begin
    ready = state == RUN;
    accept = ready & update_valid;
    we = (state == INIT) | accept;
    waddr = (state == INIT) ? ptr : up_idx;
    wdata = (state == INIT) ? CTR_BITS'(weak_nt(CTR_BITS)) :
            update_taken ? CTR_BITS'(sat_inc(4'(up_ctr), CTR_BITS)) : CTR_BITS'(sat_dec(4'(up_ctr)));
    predict_taken = ready & lk_ctr[CTR_BITS-1];
  end
  assign lk_idx = IDX_W'(bht_idx(lookup_pc, IDX_MAX'(ghr), PC_LSB, IDX_W, MODE == 1));
  assign up_idx = IDX_W'(bht_idx(update_pc, IDX_MAX'(update_hist), PC_LSB, IDX_W, MODE == 1));
  assign lookup_hist = ghr;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      ghr <= '0;
      stat_updates <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (state == INIT) ptr <= ptr + 1'b1;
      if (accept && MODE == 1) ghr <= HIST_BITS'({ghr, update_taken});
      if (accept && stat_updates != '1) stat_updates <= stat_updates + 32'd1;
      if (accept && update_mispredict && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
  bht_table #(.ENTRIES(ENTRIES), .W(CTR_BITS)) u_table (
    .clk(clk),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .ra_addr(lk_idx),
    .ra_data(lk_ctr),
    .rb_addr(up_idx),
    .rb_data(up_ctr)
  );
endmodule

// File: tb/tb_bht_predictor.sv
// tb_bht_predictor: bimodal and gshare instances checked against an array-based model
module tb_bht_predictor;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] lookup_pc, update_pc;
  logic update_valid, update_taken, update_mispredict;
  logic [7:0] uh_b, hist_b;
  logic [3:0] uh_g, hist_g;
  logic pred_b, pred_g, ready_b, ready_g;
  logic [31:0] su_b, sm_b, su_g, sm_g;
  int total = 0, bad = 0;
  int mb[64], mg[64];
  int m_init = 0, m_ghr = 0, m_upd = 0, m_mis = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  bht_predictor #(.ENTRIES(64), .CTR_BITS(2), .PC_LSB(1), .MODE(0), .HIST_BITS(8)) u_b (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .predict_taken(pred_b), .lookup_hist(hist_b),
    .ready(ready_b), .update_valid(update_valid), .update_pc(update_pc), .update_hist(uh_b),
    .update_taken(update_taken), .update_mispredict(update_mispredict),
    .stat_updates(su_b), .stat_mispredicts(sm_b));
  bht_predictor #(.ENTRIES(64), .CTR_BITS(2), .PC_LSB(1), .MODE(1), .HIST_BITS(4)) u_g (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .predict_taken(pred_g), .lookup_hist(hist_g),
    .ready(ready_g), .update_valid(update_valid), .update_pc(update_pc), .update_hist(uh_g),
    .update_taken(update_taken), .update_mispredict(update_mispredict),
    .stat_updates(su_g), .stat_mispredicts(sm_g));
  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask
  function automatic int pidx(logic [31:0] pc);
    return int'((pc >> 1) & 32'h3F);
  endfunction
  task automatic tick();
    int ib, ig;
    @(posedge clk);
    if (rst) begin
      m_init = 0; m_ghr = 0; m_upd = 0; m_mis = 0;
    end else if (m_init < 64) begin
      m_init++;
      if (m_init == 64)
        for (int i = 0; i < 64; i++) begin mb[i] = 1; mg[i] = 1; end
    end else if (update_valid) begin
      ib = pidx(update_pc);
      ig = ib ^ int'(uh_g);
      mb[ib] = update_taken ? (mb[ib] < 3 ? mb[ib] + 1 : 3) : (mb[ib] > 0 ? mb[ib] - 1 : 0);
      mg[ig] = update_taken ? (mg[ig] < 3 ? mg[ig] + 1 : 3) : (mg[ig] > 0 ? mg[ig] - 1 : 0);
      m_ghr = ((m_ghr << 1) | int'(update_taken)) & 15;
      m_upd++;
      m_mis += int'(update_mispredict);
    end
    #1;
  endtask
  task automatic upd(logic [31:0] pc, logic t, logic mp, logic [3:0] hg);
    update_pc = pc; update_taken = t; update_mispredict = mp; uh_g = hg;
    uh_b = 8'($urandom); update_valid = 1'b1;
    tick();
    update_valid = 1'b0;
    #1;
  endtask
  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  always @(negedge clk) if (chk_en) begin
    bit rdy;
    rdy = m_init >= 64;
    check("ready_b", 32'(ready_b), 32'(rdy));
    check("ready_g", 32'(ready_g), 32'(rdy));
    check("pred_b", 32'(pred_b), 32'(rdy && mb[pidx(lookup_pc)] >= 2));
    check("pred_g", 32'(pred_g), 32'(rdy && mg[pidx(lookup_pc) ^ m_ghr] >= 2));
    check("hist_b", 32'(hist_b), 32'd0);
    check("hist_g", 32'(hist_g), 32'(m_ghr));
    check("stat_upd", su_b, 32'(m_upd));
    check("stat_mis", sm_b, 32'(m_mis));
    check("stat_upd_g", su_g, 32'(m_upd));
    check("stat_mis_g", sm_g, 32'(m_mis));
  end
  initial begin
    rst = 1'b1; lookup_pc = '0; update_valid = 0; update_pc = '0; update_taken = 0;
    update_mispredict = 0; uh_b = '0; uh_g = '0;
    tick(); tick();
    chk_en = 1;
    rst = 1'b0; lookup_pc = 32'h100;
    ticks(63);
    check("init_c64_ready", 32'(ready_b), 32'd0);
    check("init_c64_pred", 32'(pred_b), 32'd0);
    tick();
    check("init_c65_ready", 32'(ready_b), 32'd1);
    check("init_c65_pred", 32'(pred_b), 32'd0);
    lookup_pc = 32'h40; #1;
    upd(32'h40, 1, 0, 0); check("sat_t1", 32'(pred_b), 32'd1);
    upd(32'h40, 1, 0, 0); upd(32'h40, 1, 0, 0); check("sat_t3", 32'(pred_b), 32'd1);
    upd(32'h40, 0, 0, 0); check("sat_n1", 32'(pred_b), 32'd1);
    upd(32'h40, 0, 0, 0); check("sat_n2", 32'(pred_b), 32'd0);
    upd(32'h40, 0, 0, 0); upd(32'h40, 0, 0, 0);
    upd(32'h40, 1, 0, 0); check("sat_floor_t1", 32'(pred_b), 32'd0);
    upd(32'h40, 1, 0, 0); check("sat_floor_t2", 32'(pred_b), 32'd1);
    lookup_pc = 32'h80; update_pc = 32'h80; update_taken = 1; update_mispredict = 0;
    update_valid = 1; #1;
    check("hazard_same", 32'(pred_b), 32'd0);
    tick(); update_valid = 0; #1;
    check("hazard_next", 32'(pred_b), 32'd1);
    upd(32'h002, 1, 0, 0); upd(32'h002, 1, 0, 0);
    lookup_pc = 32'h082; #1; check("alias_hit", 32'(pred_b), 32'd1);
    lookup_pc = 32'h004; #1; check("alias_other", 32'(pred_b), 32'd0);
    rst = 1; tick(); rst = 0;
    upd(32'h10, 1, 1, 0); upd(32'h10, 1, 1, 0);
    ticks(28);
    rst = 1; tick(); rst = 0;
    ticks(63);
    check("rst_mid_ready", 32'(ready_g), 32'd0);
    tick();
    check("rst_mid_ready1", 32'(ready_g), 32'd1);
    upd(32'h7E, 1, 1, 0); upd(32'h7E, 0, 0, 0); upd(32'h7E, 1, 0, 0); upd(32'h7E, 1, 0, 0);
    check("gshare_hist", 32'(hist_g), 32'hB);
    upd(32'h000, 1, 0, 4'b0011);
    lookup_pc = 32'h8; #1; check("gshare_idx3", 32'(pred_g), 32'd1);
    lookup_pc = 32'hE; #1; check("gshare_idx0", 32'(pred_g), 32'd0);
    upd(32'h30, 1, 1, 1); upd(32'h30, 0, 1, 2); upd(32'h30, 1, 0, 3);
    upd(32'h30, 0, 0, 4); upd(32'h30, 1, 0, 5);
    check("stats_upd", su_g, 32'd10);
    check("stats_mis", sm_g, 32'd3);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      lookup_pc = $urandom & 32'h3FF;
      update_valid = $urandom_range(0, 1) == 1;
      update_pc = $urandom & 32'h3FF;
      update_taken = $urandom_range(0, 1) == 1;
      update_mispredict = $urandom_range(0, 1) == 1;
      uh_b = 8'($urandom);
      uh_g = 4'($urandom);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
